// File: rtl/hazard_ctrl.sv
// Load-use hazard controller: stalls the front end on a load-use dependency, freezes the
// back end while load data is late, and traps into HALT_ERR on memory timeout.
// Optional macro HAZARD_PERF_CNT_EN enables the saturating stall/load-use counters.
module hazard_ctrl #(
    parameter int REG_NUM   = 32,
    parameter int MAX_WAIT  = 16,
    parameter int CNT_WIDTH = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       id_valid,
    input  logic [$clog2(REG_NUM)-1:0] id_rs1,
    input  logic [$clog2(REG_NUM)-1:0] id_rs2,
    input  logic                       id_rs1_used,
    input  logic                       id_rs2_used,
    input  logic [$clog2(REG_NUM)-1:0] ex_rd,
    input  logic                       ex_wr_reg_en,
    input  logic                       ex_is_load,
    input  logic                       mm_mem_ready,
    input  logic                       err_clr,
    output logic                       stall_fe,
    output logic                       bubble_ex,
    output logic                       freeze_be,
    output logic                       mem_timeout,
    output logic [CNT_WIDTH-1:0]       stall_cycles,
    output logic [CNT_WIDTH-1:0]       lu_events
);

    localparam int RW = $clog2(REG_NUM);
    localparam int WW = $clog2(MAX_WAIT);

    typedef enum logic [1:0] {RUN, LOAD_WAIT, HALT_ERR} state_t;

    state_t        state;
    logic [WW-1:0] wcnt;
    logic          hz;
    logic          timeout_hit;
    logic          lu_start;

    assign hz = id_valid && ex_is_load && ex_wr_reg_en && (ex_rd != RW'(0)) &&
                ((id_rs1_used && (id_rs1 == ex_rd)) || (id_rs2_used && (id_rs2 == ex_rd)));

    // Ready wins over a coincident timeout, so the check requires !mm_mem_ready.
    assign timeout_hit = (state == LOAD_WAIT) && !mm_mem_ready && !flush &&
                         (wcnt == WW'(MAX_WAIT - 1));
    assign lu_start    = (state == RUN) && hz && !flush;

    // Outputs follow live hz/flush, so they are combinational; reset and flush force them low.
    always_comb begin
        stall_fe  = 1'b0;
        bubble_ex = 1'b0;
        freeze_be = 1'b0;
        if (rst_n && !flush) begin
            case (state)
                RUN: begin
                    stall_fe  = hz;
                    bubble_ex = hz;
                end
                LOAD_WAIT: begin
                    stall_fe  = !mm_mem_ready;
                    freeze_be = !mm_mem_ready;
                end
                HALT_ERR: begin
                    stall_fe  = 1'b1;
                    freeze_be = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RUN;
            wcnt  <= '0;
        end else if (flush) begin
            state <= RUN;
            wcnt  <= '0;
        end else begin
            case (state)
                RUN: begin
                    wcnt <= '0;
                    if (hz) state <= LOAD_WAIT;
                end
                LOAD_WAIT: begin
                    if (mm_mem_ready) begin
                        state <= RUN;
                        wcnt  <= '0;
                    end else if (timeout_hit) begin
                        state <= HALT_ERR;
                        wcnt  <= '0;
                    end else begin
                        wcnt <= wcnt + WW'(1);
                    end
                end
                HALT_ERR: begin
                    wcnt <= '0;
                    if (err_clr) state <= RUN;
                end
                default: begin
                    state <= RUN;
                    wcnt  <= '0;
                end
            endcase
        end
    end

    // Sticky error flag; independent of flush so a redirect cannot hide a timeout.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)           mem_timeout <= 1'b0;
        else if (err_clr)     mem_timeout <= 1'b0;
        else if (timeout_hit) mem_timeout <= 1'b1;
    end

`ifdef HAZARD_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles <= '0;
            lu_events    <= '0;
        end else begin
            if (stall_fe && (stall_cycles != '1)) stall_cycles <= stall_cycles + CNT_WIDTH'(1);
            if (lu_start && (lu_events != '1))    lu_events    <= lu_events + CNT_WIDTH'(1);
        end
    end
`else
    assign stall_cycles = '0;
    assign lu_events    = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed-vector bench for hazard_ctrl (MAX_WAIT=4, CNT_WIDTH=8); a driver queues the
// expected outputs for each cycle and a negedge monitor pops and compares them.
module tb_hazard_ctrl;

    localparam int CW = 8;
`ifdef HAZARD_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n, flush, id_valid, id_rs1_used, id_rs2_used;
    logic [4:0]    id_rs1, id_rs2, ex_rd;
    logic          ex_wr_reg_en, ex_is_load, mm_mem_ready, err_clr;
    logic          stall_fe, bubble_ex, freeze_be, mem_timeout;
    logic [CW-1:0] stall_cycles, lu_events;

    hazard_ctrl #(.REG_NUM(32), .MAX_WAIT(4), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .id_valid(id_valid),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .ex_rd(ex_rd), .ex_wr_reg_en(ex_wr_reg_en), .ex_is_load(ex_is_load),
        .mm_mem_ready(mm_mem_ready), .err_clr(err_clr),
        .stall_fe(stall_fe), .bubble_ex(bubble_ex), .freeze_be(freeze_be),
        .mem_timeout(mem_timeout), .stall_cycles(stall_cycles), .lu_events(lu_events)
    );

    always #5 clk = ~clk;

    typedef struct {
        string    name;
        logic [3:0] o;   // {stall_fe, bubble_ex, freeze_be, mem_timeout}
        bit       cc;
        int       sc;
        int       lu;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            checks++;
            if ({stall_fe, bubble_ex, freeze_be, mem_timeout} !== e.o) begin
                errors++;
                $display("FAIL %s: outs(stall,bub,frz,to)=%b expected %b", e.name,
                         {stall_fe, bubble_ex, freeze_be, mem_timeout}, e.o);
            end
            if (e.cc) begin
                checks++;
                if (stall_cycles !== CW'(e.sc) || lu_events !== CW'(e.lu)) begin
                    errors++;
                    $display("FAIL %s.cnt: stall_cycles=%0d lu_events=%0d expected %0d %0d",
                             e.name, stall_cycles, lu_events, e.sc, e.lu);
                end
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clr_in;
        id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_rs1_used = 0; id_rs2_used = 0;
        ex_rd = 0; ex_wr_reg_en = 0; ex_is_load = 0;
    endtask

    task automatic hz_in(input logic [4:0] rs1, input logic u1, input logic [4:0] rs2,
                         input logic u2, input logic [4:0] rd, input logic ld);
        id_valid = 1; id_rs1 = rs1; id_rs1_used = u1; id_rs2 = rs2; id_rs2_used = u2;
        ex_rd = rd; ex_wr_reg_en = 1; ex_is_load = ld;
    endtask

    task automatic vec(input string n, input logic [3:0] o, input bit cc, input int sc,
                       input int lu);
        exp_t e;
        e.name = n; e.o = o; e.cc = cc;
        e.sc = PERF ? sc : 0;
        e.lu = PERF ? lu : 0;
        q.push_back(e);
        tick();
    endtask

    initial begin
        rst_n = 0; flush = 0; mm_mem_ready = 0; err_clr = 0;
        clr_in();
        tick();
        // reset holds outputs low even with a live hazard
        hz_in(5, 1, 0, 0, 5, 1);
        vec("rst_hold", 4'b0000, 1, 0, 0);
        rst_n = 1; clr_in();
        vec("idle", 4'b0000, 1, 0, 0);
        // false hazards
        hz_in(0, 1, 0, 0, 0, 1);  vec("nofh_rd0", 4'b0000, 0, 0, 0);
        hz_in(5, 0, 0, 0, 5, 1);  vec("nofh_unused", 4'b0000, 0, 0, 0);
        hz_in(5, 1, 0, 0, 5, 0);  vec("nofh_noload", 4'b0000, 0, 0, 0);
        clr_in();                 vec("nofh_after", 4'b0000, 1, 0, 0);
        // basic load-use with ready on the next cycle
        hz_in(5, 1, 0, 0, 5, 1);  vec("lu_hz", 4'b1100, 1, 0, 0);
        clr_in(); mm_mem_ready = 1; vec("lu_ready", 4'b0000, 1, 1, 1);
        mm_mem_ready = 0;         vec("lu_run", 4'b0000, 1, 1, 1);
        // memory wait of 3 cycles, hazard via rs2
        hz_in(3, 1, 7, 1, 7, 1);  vec("mw_hz", 4'b1100, 1, 1, 1);
        clr_in();
        vec("mw_wait1", 4'b1010, 1, 2, 2);
        vec("mw_wait2", 4'b1010, 1, 3, 2);
        vec("mw_wait3", 4'b1010, 1, 4, 2);
        mm_mem_ready = 1;         vec("mw_ready", 4'b0000, 1, 5, 2);
        // back-to-back hazards
        mm_mem_ready = 0; hz_in(9, 1, 0, 0, 9, 1); vec("b2b_hz1", 4'b1100, 1, 5, 2);
        clr_in(); mm_mem_ready = 1; vec("b2b_rdy1", 4'b0000, 1, 6, 3);
        mm_mem_ready = 0; hz_in(4, 1, 0, 0, 4, 1); vec("b2b_hz2", 4'b1100, 1, 6, 3);
        clr_in(); mm_mem_ready = 1; vec("b2b_rdy2", 4'b0000, 1, 7, 4);
        mm_mem_ready = 0;         vec("b2b_idle", 4'b0000, 1, 7, 4);
        // ready on the would-be timeout cycle resolves as ready
        hz_in(6, 1, 0, 0, 6, 1);  vec("rt_hz", 4'b1100, 1, 7, 4);
        clr_in();
        vec("rt_w1", 4'b1010, 1, 8, 5);
        vec("rt_w2", 4'b1010, 1, 9, 5);
        vec("rt_w3", 4'b1010, 1, 10, 5);
        mm_mem_ready = 1;         vec("rt_ready", 4'b0000, 1, 11, 5);
        mm_mem_ready = 0;         vec("rt_no_to", 4'b0000, 1, 11, 5);
        // timeout after 4 wait cycles, HALT_ERR holds, err_clr exits
        hz_in(8, 1, 0, 0, 8, 1);  vec("to_hz", 4'b1100, 1, 11, 5);
        clr_in();
        vec("to_w1", 4'b1010, 1, 12, 6);
        vec("to_w2", 4'b1010, 1, 13, 6);
        vec("to_w3", 4'b1010, 1, 14, 6);
        vec("to_w4", 4'b1010, 1, 15, 6);
        vec("to_halt1", 4'b1011, 1, 16, 6);
        hz_in(8, 1, 0, 0, 8, 1);  vec("to_halt2", 4'b1011, 1, 17, 6);
        clr_in(); err_clr = 1;    vec("to_clr", 4'b1011, 1, 18, 6);
        err_clr = 0;              vec("to_run", 4'b0000, 1, 19, 6);
        // flush during the second wait cycle
        hz_in(2, 1, 0, 0, 2, 1);  vec("fl_hz", 4'b1100, 1, 19, 6);
        clr_in();                 vec("fl_w1", 4'b1010, 1, 20, 7);
        flush = 1;                vec("fl_flush", 4'b0000, 1, 21, 7);
        flush = 0;                vec("fl_run", 4'b0000, 1, 21, 7);
        // full wait count after flush proves wcnt restarted
        hz_in(2, 1, 0, 0, 2, 1);  vec("fl2_hz", 4'b1100, 1, 21, 7);
        clr_in();
        vec("fl2_w1", 4'b1010, 1, 22, 8);
        vec("fl2_w2", 4'b1010, 1, 23, 8);
        vec("fl2_w3", 4'b1010, 1, 24, 8);
        vec("fl2_w4", 4'b1010, 1, 25, 8);
        vec("fl2_halt", 4'b1011, 1, 26, 8);
        // flush in HALT_ERR leaves mem_timeout set
        flush = 1;                vec("fh_flush", 4'b0001, 1, 27, 8);
        flush = 0;                vec("fh_run", 4'b0001, 1, 27, 8);
        err_clr = 1;              vec("fh_clr", 4'b0001, 1, 27, 8);
        err_clr = 0;              vec("fh_clean", 4'b0000, 1, 27, 8);
        // counter saturation while parked in HALT_ERR
        hz_in(1, 1, 0, 0, 1, 1);  vec("sat_hz", 4'b1100, 1, 27, 8);
        clr_in();
        for (int i = 0; i < 4; i++) vec("sat_wait", 4'b1010, 0, 0, 0);
        for (int i = 0; i < 250; i++) vec("sat_halt", 4'b1011, 0, 0, 0);
        vec("sat_chk", 4'b1011, 1, 255, 9);
        vec("sat_hold", 4'b1011, 1, 255, 9);
        err_clr = 1;              vec("sat_clr", 4'b1011, 1, 255, 9);
        err_clr = 0;              vec("sat_run", 4'b0000, 1, 255, 9);
        // asynchronous reset mid-wait
        hz_in(5, 1, 0, 0, 5, 1);  vec("rw_hz", 4'b1100, 0, 0, 0);
        clr_in();                 vec("rw_wait", 4'b1010, 0, 0, 0);
        hz_in(5, 1, 0, 0, 5, 1); rst_n = 0; vec("rst_mid", 4'b0000, 1, 0, 0);
        clr_in(); rst_n = 1;      vec("rst_rel", 4'b0000, 1, 0, 0);
        hz_in(5, 1, 0, 0, 5, 1);  vec("post_hz", 4'b1100, 1, 0, 0);
        clr_in(); mm_mem_ready = 1; vec("post_rdy", 4'b0000, 1, 1, 1);
        mm_mem_ready = 0;

        for (int i = 0; i < 10 && q.size() > 0; i++) tick();
        if (q.size() > 0) begin
            errors++;
            checks++;
            $display("FAIL drain: %0d expectations left unchecked, expected 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter REG_NUM, default 32, number of architectural registers; register index width is clog2(REG_NUM).
REQ-002 SHALL have parameter MAX_WAIT, default 16, memory-wait cycles before timeout; legal range 2..255.
REQ-003 SHALL have parameter CNT_WIDTH, default 32, width of the performance counters.
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on the rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port flush  input  1  pipeline flush (branch redirect or trap).
REQ-007 SHALL have port id_valid  input  1  valid instruction in ID.
REQ-008 SHALL have ports id_rs1, id_rs2  input  clog2(REG_NUM)  ID source indices.
REQ-009 SHALL have ports id_rs1_used, id_rs2_used  input  1  source is actually read.
REQ-010 SHALL have ports ex_rd  input  clog2(REG_NUM), ex_wr_reg_en  input  1, ex_is_load  input  1  EX destination, write enable, and load flag.
REQ-011 SHALL have port mm_mem_ready  input  1  load data valid in MM this cycle.
REQ-012 SHALL have port stall_fe  output  1  hold the PC and IF/ID.
REQ-013 SHALL have port bubble_ex  output  1  inject a NOP into ID/EX.
REQ-014 SHALL have port freeze_be  output  1  hold ID/EX, EX/MM, and MM/WB.
REQ-015 SHALL have port mem_timeout  output  1  sticky timeout error flag.
REQ-016 SHALL have port err_clr  input  1  clears mem_timeout.
REQ-017 SHALL have ports stall_cycles, lu_events  output  CNT_WIDTH  performance counters.

Function
REQ-018 SHALL compute the load-use hazard (hz) combinationally:
- id_valid & ex_is_load & ex_wr_reg_en & ex_rd != 0
- and (id_rs1_used & id_rs1 == ex_rd, or id_rs2_used & id_rs2 == ex_rd).
REQ-019 SHALL implement a FSM with states RUN, LOAD_WAIT, and HALT_ERR, where the state resets to RUN.
REQ-020 In RUN, the block SHALL drive:
- stall_fe = hz, bubble_ex = hz, freeze_be = 0
- next state = LOAD_WAIT if hz, else RUN.
REQ-021 In LOAD_WAIT with mm_mem_ready = 1, the block SHALL drive all stall outputs 0 and return to RUN; the dependent instruction then proceeds with MM-load forwarding.
REQ-022 In LOAD_WAIT with mm_mem_ready = 0, the block SHALL drive:
- stall_fe = 1, freeze_be = 1, bubble_ex = 0
- wait counter (wcnt) increments by 1.
REQ-023 SHALL clear wcnt on every entry to LOAD_WAIT and in every state other than LOAD_WAIT.
REQ-024 When wcnt == MAX_WAIT-1 and mm_mem_ready = 0 in LOAD_WAIT, the block SHALL set mem_timeout on the next edge and go to HALT_ERR.
REQ-025 In HALT_ERR, the block SHALL hold stall_fe = 1 and freeze_be = 1; it exits to RUN only on err_clr or flush.
REQ-026 err_clr SHALL clear mem_timeout on the next edge.
REQ-027 mm_mem_ready and timeout in the same cycle SHALL resolve as ready; no timeout is raised.
REQ-028 flush SHALL override everything:
- stall_fe, bubble_ex, and freeze_be are 0 in that cycle (combinational)
- next state = RUN, wcnt = 0
- mem_timeout is unchanged unless err_clr is also asserted.
REQ-029 Back-to-back hazards SHALL each be handled as follows: a hazard detected in the RUN cycle right after leaving LOAD_WAIT stalls again.

Reset
REQ-030 While rst_n = 0, the block SHALL asynchronously force:
- state = RUN, wcnt = 0, mem_timeout = 0
- stall_cycles = 0, lu_events = 0.
REQ-031 During reset, stall_fe, bubble_ex, and freeze_be SHALL be 0 regardless of inputs.
REQ-032 Reset asserted mid-LOAD_WAIT or in HALT_ERR SHALL abandon the wait with no pending state retained.

Configuration
REQ-033 With macro HAZARD_PERF_CNT_EN defined, the performance counters SHALL behave as follows:
- stall_cycles increments each cycle stall_fe = 1.
- lu_events increments each RUN->LOAD_WAIT transition.
- Both saturate at all-ones and do not wrap.
REQ-034 Without HAZARD_PERF_CNT_EN, stall_cycles and lu_events SHALL be constant 0 with no counter flops; all other behaviour is identical.

Verification
REQ-035 SHALL verify the basic load-use stall: EX load with ex_rd = 5, ID rs1 = 5 used, mm_mem_ready = 1 on the next cycle -> stall_fe and bubble_ex high for exactly 1 cycle, then RUN.
REQ-036 SHALL verify no false hazard:
- ex_rd = 0, or id_rs1_used = 0, or ex_is_load = 0 with a matching index -> stall_fe = 0 and state stays RUN.
REQ-037 SHALL verify memory wait: hazard, then mm_mem_ready low for 3 cycles -> freeze_be high 3 cycles, stall_fe high 4 cycles total, lu_events = 1, stall_cycles = 4 (macro on).
REQ-038 SHALL verify timeout, with MAX_WAIT = 4:
- ready never asserted -> mem_timeout set after 4 wait cycles, HALT_ERR holds
- err_clr pulse -> RUN and mem_timeout = 0.
REQ-039 SHALL verify flush in LOAD_WAIT during the second wait cycle -> all stall outputs 0 in that cycle, RUN next, wcnt = 0.
REQ-040 SHALL verify async reset asserted mid-wait -> outputs 0 immediately, counters 0, RUN after release.
